// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the accumulator datapath.
// Optional CONTROL_UNIT_MEM_WAIT_EN adds data_memory_ready_in to stall MEM and STO.
module control_unit #(
  parameter int DATA_WIDTH   = 11,
  parameter int OPCODE_WIDTH = 5,
  parameter int ADDR_WIDTH   = 11
) (
  input  logic                               clock_in,
  input  logic                               reset_in,
  input  logic                               run_in,
  input  logic [OPCODE_WIDTH+DATA_WIDTH-1:0] instruction_in,
  input  logic                               flag_Z_in,
  input  logic                               flag_N_in,
`ifdef CONTROL_UNIT_MEM_WAIT_EN
  input  logic                               data_memory_ready_in,
`endif
  output logic [ADDR_WIDTH-1:0]              instruction_address_out,
  output logic [DATA_WIDTH-1:0]              operand_out,
  output logic                               op_alu_out,
  output logic [1:0]                         sel_A_out,
  output logic                               sel_B_out,
  output logic                               acc_wr_out,
  output logic                               status_wr_out,
  output logic                               acc_reset_out,
  output logic                               status_reset_out,
  output logic                               data_memory_wr_out,
  output logic                               halted_out
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'('h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'('h01);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'('h02);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'('h03);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'('h04);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'('h05);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'('h06);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'('h07);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'('h08);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'('h09);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'('h0A);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'('h0B);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'('h0C);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = OPCODE_WIDTH'('h0D);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'('h0E);

  state_t                            state_q;
  logic [ADDR_WIDTH-1:0]             pc_q;
  logic [OPCODE_WIDTH+DATA_WIDTH-1:0] ir_q;
  logic [OPCODE_WIDTH-1:0]           opcode;
  logic                              taken;
  logic                              mem_rdy;

  assign opcode                  = ir_q[OPCODE_WIDTH+DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign operand_out             = ir_q[DATA_WIDTH-1:0];
  assign instruction_address_out = pc_q;

`ifdef CONTROL_UNIT_MEM_WAIT_EN
  assign mem_rdy = data_memory_ready_in;
`else
  assign mem_rdy = 1'b1;
`endif

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = flag_Z_in;
      OP_BNE:  taken = !flag_Z_in;
      OP_BLT:  taken = flag_N_in;
      OP_BGE:  taken = !flag_N_in;
      OP_BGT:  taken = !flag_Z_in && !flag_N_in;
      OP_BLE:  taken = flag_Z_in || flag_N_in;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE:   if (run_in) state_q <= S_FETCH;
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          ir_q    <= instruction_in;
          pc_q    <= pc_q + ADDR_WIDTH'(1);
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          case (opcode)
            OP_HLT:                state_q <= S_HALT;
            OP_LD, OP_ADD, OP_SUB: state_q <= S_MEM;
            OP_STO:                if (mem_rdy) state_q <= S_FETCH;
            default: begin
              // a taken branch replaces the increment made in DECODE
              if (taken) pc_q <= operand_out[ADDR_WIDTH-1:0];
              state_q <= S_FETCH;
            end
          endcase
        end
        S_MEM:    if (mem_rdy) state_q <= S_FETCH;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    op_alu_out         = 1'b0;
    sel_A_out          = 2'b00;
    sel_B_out          = 1'b0;
    acc_wr_out         = 1'b0;
    status_wr_out      = 1'b0;
    acc_reset_out      = 1'b0;
    status_reset_out   = 1'b0;
    data_memory_wr_out = 1'b0;
    halted_out         = 1'b0;
    case (state_q)
      S_IDLE: begin
        acc_reset_out    = 1'b1;
        status_reset_out = 1'b1;
      end
      S_EXEC: begin
        case (opcode)
          OP_STO: data_memory_wr_out = 1'b1;
          OP_LDI: begin
            sel_A_out  = 2'b01;
            acc_wr_out = 1'b1;
          end
          OP_ADDI, OP_SUBI: begin
            op_alu_out    = (opcode == OP_SUBI);
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // the data read issued in EXEC is consumed here
        if (mem_rdy) begin
          case (opcode)
            OP_LD: begin
              sel_A_out  = 2'b10;
              acc_wr_out = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              sel_B_out     = 1'b1;
              op_alu_out    = (opcode == OP_SUB);
              acc_wr_out    = 1'b1;
              status_wr_out = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_HALT:  halted_out = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: memories + datapath environment and an instruction-level reference model.
module tb_control_unit;
  localparam int DW = 11, OW = 5, AW = 11;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic grst_n = 1'b0, run = 1'b0;
  logic [OW+DW-1:0] instr;
  logic z_f, n_f;
  logic [AW-1:0] addr;
  logic [DW-1:0] operand;
  logic op_alu, sel_b, acc_wr, st_wr, acc_rst, st_rst, dm_wr, halted;
  logic [1:0] sel_a;

  control_unit #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .ADDR_WIDTH(AW)) dut (
    .clock_in(gclk), .reset_in(grst_n), .run_in(run), .instruction_in(instr),
    .flag_Z_in(z_f), .flag_N_in(n_f),
`ifdef CONTROL_UNIT_MEM_WAIT_EN
    .data_memory_ready_in(1'b1),
`endif
    .instruction_address_out(addr), .operand_out(operand), .op_alu_out(op_alu),
    .sel_A_out(sel_a), .sel_B_out(sel_b), .acc_wr_out(acc_wr), .status_wr_out(st_wr),
    .acc_reset_out(acc_rst), .status_reset_out(st_rst), .data_memory_wr_out(dm_wr),
    .halted_out(halted)
  );

  // environment: sync imem, sync dmem, accumulator datapath
  logic [OW+DW-1:0] imem [2048];
  logic [DW-1:0] dmem [2048];
  logic [DW-1:0] dmem_init [2048];
  logic [DW-1:0] rdata, acc, bsrc, alu;
  logic load = 1'b0;

  assign bsrc = sel_b ? rdata : operand;
  assign alu  = op_alu ? acc - bsrc : acc + bsrc;

  always @(posedge gclk) begin
    instr <= imem[addr];
    rdata <= dmem[operand];
    if (load) for (int i = 0; i < 2048; i++) dmem[i] <= dmem_init[i];
    else if (dm_wr) dmem[operand] <= acc;
    if (acc_rst) acc <= '0;
    else if (acc_wr) acc <= (sel_a == 2'b01) ? operand : (sel_a == 2'b10) ? rdata : alu;
    if (st_rst) begin z_f <= 1'b0; n_f <= 1'b0; end
    else if (st_wr) begin z_f <= (alu == '0); n_f <= alu[DW-1]; end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // strobe vector: {halted, dm_wr, st_rst, acc_rst, st_wr, acc_wr, selB, selA, op}
  function automatic logic [9:0] mkv(bit h, bit dw, bit sr, bit ar, bit sw, bit aw, bit sb,
                                     logic [1:0] sa, bit o);
    return {h, dw, sr, ar, sw, aw, sb, sa, o};
  endfunction

  function automatic logic [9:0] dutv();
    return {halted, dm_wr, st_rst, acc_rst, st_wr, acc_wr, sel_b, sel_a, op_alu};
  endfunction

  function automatic logic [OW+DW-1:0] ins(int op, int od);
    return {OW'(op), DW'(od)};
  endfunction

  logic [DW-1:0] mdm [2048];

  task automatic start();
    grst_n = 1'b0; run = 1'b0; load = 1'b1;
    @(posedge gclk); #1 load = 1'b0;
    @(negedge gclk);
    chk("rst_pc", 32'(addr), 0);
    chk("rst_strb", 32'(dutv()), 32'(mkv(0,0,1,1,0,0,0,2'b00,0)));
    for (int i = 0; i < 2048; i++) mdm[i] = dmem_init[i];
    grst_n = 1'b1; run = 1'b1;
    #1 chk("idle_strb", 32'(dutv()), 32'(mkv(0,0,1,1,0,0,0,2'b00,0)));
  endtask

  // executes n instructions from PC 0 at instruction level and checks every cycle
  task automatic run_prog(input int n);
    logic [AW-1:0] mpc, npc1;
    logic [DW-1:0] macc, od, res;
    logic mz, mn, tk, memop;
    logic [9:0] exv, memv;
    int op;
    start();
    mpc = '0; macc = '0; mz = 1'b0; mn = 1'b0;
    for (int i = 0; i < n; i++) begin
      op = int'(imem[mpc][OW+DW-1:DW]);
      od = imem[mpc][DW-1:0];
      npc1 = mpc + 1'b1;
      memop = (op == 2 || op == 4 || op == 6);
      exv = '0; memv = '0; res = macc;
      case (op)
        1: exv = mkv(0,1,0,0,0,0,0,2'b00,0);
        3: exv = mkv(0,0,0,0,0,1,0,2'b01,0);
        5: exv = mkv(0,0,0,0,1,1,0,2'b00,0);
        7: exv = mkv(0,0,0,0,1,1,0,2'b00,1);
        2: memv = mkv(0,0,0,0,0,1,0,2'b10,0);
        4: memv = mkv(0,0,0,0,1,1,1,2'b00,0);
        6: memv = mkv(0,0,0,0,1,1,1,2'b00,1);
        default: ;
      endcase
      case (op)
        8: tk = mz;       9: tk = !mz;
        10: tk = mn;      11: tk = !mn;
        12: tk = !mz && !mn;
        13: tk = mz || mn;
        14: tk = 1'b1;
        default: tk = 1'b0;
      endcase
      @(negedge gclk);
      chk("f_pc", 32'(addr), 32'(mpc));
      chk("f_strb", 32'(dutv()), 0);
      chk("acc", 32'(acc), 32'(macc));
      @(negedge gclk);
      chk("d_pc", 32'(addr), 32'(mpc));
      chk("d_strb", 32'(dutv()), 0);
      @(negedge gclk);
      chk("e_pc", 32'(addr), 32'(npc1));
      chk("e_strb", 32'(dutv()), 32'(exv));
      chk("e_opd", 32'(operand), 32'(od));
      if (memop) begin
        @(negedge gclk);
        chk("m_pc", 32'(addr), 32'(npc1));
        chk("m_strb", 32'(dutv()), 32'(memv));
        chk("m_opd", 32'(operand), 32'(od));
      end
      if (op == 0) begin
        repeat (3) begin
          @(negedge gclk);
          chk("h_strb", 32'(dutv()), 32'(mkv(1,0,0,0,0,0,0,2'b00,0)));
          chk("h_pc", 32'(addr), 32'(npc1));
        end
        return;
      end
      case (op)
        1: mdm[od] = macc;
        2: macc = mdm[od];
        3: macc = od;
        4: res = macc + mdm[od];
        5: res = macc + od;
        6: res = macc - mdm[od];
        7: res = macc - od;
        default: ;
      endcase
      if (op >= 4 && op <= 7) begin
        macc = res; mz = (res == '0); mn = res[DW-1];
      end
      mpc = tk ? od[AW-1:0] : npc1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) begin
      imem[i] = ins(16, 0);
      dmem_init[i] = '0;
    end
  endtask

  initial begin
    clear_mem();
    // LDI 5; HLT
    imem[0] = ins(3, 5); imem[1] = ins(0, 0);
    run_prog(2);
    // LD/ADD/STO through data memory
    clear_mem();
    dmem_init[11'h010] = 11'd7; dmem_init[11'h011] = 11'd3;
    imem[0] = ins(2, 'h010); imem[1] = ins(4, 'h011); imem[2] = ins(1, 'h012); imem[3] = ins(0, 0);
    run_prog(4);
    chk("sto_mem", 32'(dmem[11'h012]), 10);
    // BEQ taken / not taken, BLT taken, BGT not taken
    clear_mem();
    imem[0] = ins(3, 3); imem[1] = ins(7, 3); imem[2] = ins(8, 'h020);
    run_prog(4);
    imem[1] = ins(7, 2);
    run_prog(4);
    imem[0] = ins(3, 1); imem[1] = ins(7, 2); imem[2] = ins(10, 'h040);
    run_prog(4);
    imem[2] = ins(12, 'h040);
    run_prog(4);
    // PC wrap from 0x7FF
    clear_mem();
    imem[0] = ins(14, 'h7FF);
    run_prog(4);
    // reset during MEM of ADD aborts the write
    clear_mem();
    imem[0] = ins(4, 5); dmem_init[5] = 11'd9;
    start();
    repeat (4) @(negedge gclk);
    chk("mem_pre", 32'(dutv()), 32'(mkv(0,0,0,0,1,1,1,2'b00,0)));
    grst_n = 1'b0;
    #1 chk("mem_rst_strb", 32'(dutv()), 32'(mkv(0,0,1,1,0,0,0,2'b00,0)));
    chk("mem_rst_pc", 32'(addr), 0);
    @(posedge gclk); #1 chk("mem_rst_acc", 32'(acc), 0);
    // random programs
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 2048; i++) begin
        int op;
        op = $urandom_range(0, 31);
        if (op == 0 && ($urandom % 8) != 0) op = 16;
        imem[i] = ins(op, $urandom_range(0, 2047));
        dmem_init[i] = DW'($urandom);
      end
      run_prog(150);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
